// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC front end: FSM states, quadrant tag, saturating negate.
package cordic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_RUN,
      ST_OUT
   } state_t;

   typedef logic [1:0] quad_t;

   localparam int LAUNCH_TIMEOUT = 2;

   // Negation is done at this width and the caller truncates, so any DW up to SAT_W works.
   localparam int SAT_W = 64;

   function automatic logic signed [SAT_W-1:0] sat_neg(input logic signed [SAT_W-1:0] v,
                                                       input int w);
      logic signed [SAT_W-1:0] most_neg;
      most_neg = {SAT_W{1'b1}} << (w - 1);
      return (v == most_neg) ? ~most_neg : -v;
   endfunction

endpackage

// File: rtl/cordic_quad_fix.sv
// Combinational quadrant correction of raw datapath (x, y) back to full-circle (cos, sin).
// Zero latency, no handshake; -(most negative) saturates to most positive.
module cordic_quad_fix
   import cordic_pkg::*;
#(
   parameter int DW = 16
) (
   input  quad_t         quad,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   output logic [DW-1:0] rot_x,
   output logic [DW-1:0] rot_y
);

   logic [DW-1:0] neg_x;
   logic [DW-1:0] neg_y;

   assign neg_x = DW'(sat_neg({{(SAT_W-DW){x[DW-1]}}, x}, DW));
   assign neg_y = DW'(sat_neg({{(SAT_W-DW){y[DW-1]}}, y}, DW));

   always_comb begin
      rot_x = x;
      rot_y = y;
      case (quad)
         2'd0: begin rot_x = x;     rot_y = y;     end
         2'd1: begin rot_x = neg_y; rot_y = x;     end
         2'd2: begin rot_x = neg_x; rot_y = neg_y; end
         2'd3: begin rot_x = y;     rot_y = neg_x; end
         default: ;
      endcase
   end

endmodule

// File: rtl/cordic_frontend.sv
// Folds a full-circle phase into [0,90deg), runs the CORDIC control unit once, un-folds x/y into cos/sin.
// Accept-to-valid is 3N+5 cycles for an N-iteration unit; result held until out_ready, no accept bypass.
module cordic_frontend
   import cordic_pkg::*;
#(
   parameter int ANG_W   = 16,
   parameter int DW      = 16,
   parameter int MAX_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ANG_W-1:0] in_phase,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_cos,
   output logic [DW-1:0]    out_sin,
   output logic             out_err,
   output logic             cu_en,
   input  logic             cu_busy,
   output logic [ANG_W-1:0] dp_angle,
   input  logic [DW-1:0]    dp_x,
   input  logic [DW-1:0]    dp_y
);

   localparam int WD_W = $clog2(MAX_CYC + 1);

   state_t          state;
   state_t          state_nxt;
   quad_t           quad;
   logic [WD_W-1:0] wdog;
   logic [DW-1:0]   fix_cos;
   logic [DW-1:0]   fix_sin;
   logic            accept;
   logic            wd_fire;
   logic            launch_to;
   logic            fire;
   logic            capture;

   cordic_quad_fix #(.DW(DW)) u_quad_fix (
      .quad  (quad),
      .x     (dp_x),
      .y     (dp_y),
      .rot_x (fix_cos),
      .rot_y (fix_sin)
   );

   assign accept    = (state == ST_IDLE) && in_valid;
   assign wd_fire   = ((state == ST_LAUNCH) || (state == ST_RUN)) && (wdog == WD_W'(MAX_CYC - 1));
   assign launch_to = (state == ST_LAUNCH) && !cu_busy && (wdog >= WD_W'(LAUNCH_TIMEOUT - 1));
   assign fire      = wd_fire || launch_to;
   assign capture   = (state == ST_RUN) && !cu_busy && !wd_fire;

   // cu_en follows busy combinationally in RUN so the unit never sees enable after it finishes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      cu_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (fire) begin
               state_nxt = ST_OUT;
            end else begin
               cu_en = 1'b1;
               if (cu_busy) state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (fire || !cu_busy) state_nxt = ST_OUT;
            else                  cu_en     = 1'b1;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         quad     <= '0;
         dp_angle <= '0;
         wdog     <= '0;
         out_cos  <= '0;
         out_sin  <= '0;
         out_err  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (accept) begin
            quad     <= in_phase[ANG_W-1:ANG_W-2];
            dp_angle <= {2'b00, in_phase[ANG_W-3:0]};
            wdog     <= '0;
         end else if ((state == ST_LAUNCH) || (state == ST_RUN)) begin
            wdog <= wdog + WD_W'(1);
         end

         if (fire) begin
            out_cos <= '0;
            out_sin <= '0;
            out_err <= 1'b1;
         end else if (capture) begin
            out_cos <= fix_cos;
            out_sin <= fix_sin;
            out_err <= 1'b0;
         end else if ((state == ST_OUT) && out_ready) begin
            out_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cordic_frontend.sv
// Directed and randomized checks of cordic_frontend against a behavioural control-unit model and a rotation reference.
module tb_cordic_frontend;

   localparam int N              = 7;
   localparam int MAX_CYC        = 64;
   localparam int LAUNCH_TIMEOUT = 2;
   localparam int CU_OK          = 0;
   localparam int CU_NEVER       = 1;
   localparam int CU_STUCK       = 2;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_phase;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_cos;
   logic [15:0] out_sin;
   logic        out_err;
   logic        cu_en;
   logic        cu_busy;
   logic [15:0] dp_angle;
   logic [15:0] dp_x;
   logic [15:0] dp_y;

   int errors;
   int checks;
   int cu_mode;
   int busy_left;
   int starts;

   cordic_frontend #(.ANG_W(16), .DW(16), .MAX_CYC(MAX_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_phase  (in_phase),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin),
      .out_err   (out_err),
      .cu_en     (cu_en),
      .cu_busy   (cu_busy),
      .dp_angle  (dp_angle),
      .dp_x      (dp_x),
      .dp_y      (dp_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int clampw(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Rotate (x, y) by quadrant*90 degrees, then clamp to the 16-bit signed range.
   function automatic void ref_rot(input logic [15:0] phase, input logic [15:0] x,
                                   input logic [15:0] y, output logic [15:0] c,
                                   output logic [15:0] s);
      int q, cq, sq, xi, yi;
      q  = int'(phase) / 16384;
      cq = (q == 0) ? 1 : (q == 2) ? -1 : 0;
      sq = (q == 1) ? 1 : (q == 3) ? -1 : 0;
      xi = $signed(x);
      yi = $signed(y);
      c  = 16'(clampw(cq * xi - sq * yi));
      s  = 16'(clampw(sq * xi + cq * yi));
   endfunction

   // One clock; the control-unit model reacts to the enable it saw during the cycle just ended.
   task automatic tick();
      logic en_prev;
      en_prev = cu_en;
      @(posedge clk);
      #1;
      if (rst) begin
         busy_left = 0;
      end else if (busy_left > 0) begin
         if (cu_mode != CU_STUCK) busy_left--;
      end else if (en_prev === 1'b1 && cu_mode != CU_NEVER) begin
         busy_left = 3 * N + 2;
         starts++;
      end
      cu_busy = (busy_left > 0);
      #3;
   endtask

   task automatic do_req(input logic [15:0] phase, input logic [15:0] x, input logic [15:0] y,
                         input int mode, input int hold);
      int          lat_exp, t, en_cnt, en_last, ready_bad, ang_bad, hold_bad, starts0;
      logic [15:0] c_exp, s_exp, ang_exp, c_seen, s_seen;
      logic        err_exp;
      lat_exp = (mode == CU_OK) ? 3 * N + 5 : (mode == CU_NEVER) ? LAUNCH_TIMEOUT + 1 : MAX_CYC + 1;
      err_exp = (mode != CU_OK);
      if (err_exp) begin
         c_exp = '0;
         s_exp = '0;
      end else begin
         ref_rot(phase, x, y, c_exp, s_exp);
      end
      ang_exp = 16'(int'(phase) % 16384);

      cu_mode  = mode;
      dp_x     = x;
      dp_y     = y;
      in_phase = phase;
      in_valid = 1'b1;
      starts0  = starts;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_cu_en", cu_en, 0);
      tick();

      t = 1; en_cnt = 0; en_last = 0; ready_bad = 0; ang_bad = 0;
      while (t <= 200 && out_valid !== 1'b1) begin
         if (cu_en === 1'b1) begin
            en_cnt++;
            en_last = t;
         end
         if (in_ready !== 1'b0) ready_bad++;
         if (dp_angle !== ang_exp) ang_bad++;
         in_valid = 1'($urandom);
         in_phase = 16'($urandom);
         tick();
         t++;
      end
      in_valid = 1'b0;

      // Enable is high from the LAUNCH cycle through the last busy cycle: every cycle but the last two.
      chk("latency", t, lat_exp);
      chk("cu_en_cycles", en_cnt, lat_exp - 2);
      chk("cu_en_last", en_last, lat_exp - 2);
      chk("in_ready_busy", ready_bad, 0);
      chk("dp_angle_run", ang_bad, 0);
      chk("dp_angle", dp_angle, ang_exp);
      chk("out_err", out_err, err_exp);
      chk("out_cos", out_cos, c_exp);
      chk("out_sin", out_sin, s_exp);

      c_seen   = out_cos;
      s_seen   = out_sin;
      hold_bad = 0;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (out_valid !== 1'b1 || out_cos !== c_seen || out_sin !== s_seen ||
             out_err !== err_exp || in_ready !== 1'b0 || cu_en !== 1'b0 || dp_angle !== ang_exp)
            hold_bad++;
      end
      chk("hold_stable", hold_bad, 0);
      chk("cu_starts", starts - starts0, (mode == CU_NEVER) ? 0 : 1);

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      chk("post_out_err", out_err, 0);
   endtask

   initial begin
      logic [15:0] ph, rx, ry;
      errors    = 0;
      checks    = 0;
      cu_mode   = CU_OK;
      busy_left = 0;
      starts    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_phase  = '0;
      out_ready = 1'b0;
      cu_busy   = 1'b0;
      dp_x      = '0;
      dp_y      = '0;

      repeat (2) @(posedge clk);
      #4;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_cos", out_cos, 0);
      chk("rst_out_sin", out_sin, 0);
      chk("rst_cu_en", cu_en, 0);
      chk("rst_dp_angle", dp_angle, 0);
      rst = 1'b0;
      tick();

      do_req(16'h0000, 16'h4000, 16'h0000, CU_OK, 0);
      do_req(16'h5000, 16'h3000, 16'h1000, CU_OK, 1);
      do_req(16'h8000, 16'h8000, 16'h0001, CU_OK, 0);
      do_req(16'h6abc, 16'h1234, 16'h8000, CU_OK, 5);
      do_req(16'h1111, 16'h2222, 16'h3333, CU_NEVER, 2);
      do_req(16'hd000, 16'h0100, 16'h0200, CU_STUCK, 1);
      cu_mode   = CU_OK;
      busy_left = 0;
      cu_busy   = 1'b0;
      tick();

      // Reset in the middle of a run must drop enable and valid without a clock edge.
      cu_mode  = CU_OK;
      in_phase = 16'h1234;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("mid_run_cu_en", cu_en, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_cu_en", cu_en, 0);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_dp_angle", dp_angle, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("after_rst_in_ready", in_ready, 1);
      do_req(16'hc000, 16'h2000, 16'h0000, CU_OK, 0);

      for (int i = 0; i < 10; i++) begin
         ph = 16'($urandom);
         rx = 16'($urandom);
         ry = 16'($urandom);
         if (i % 3 == 0) rx = 16'h8000;
         if (i % 4 == 1) ry = 16'h8000;
         do_req(ph, rx, ry, CU_OK, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
